// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep sequencer: default widths and state encoding.
package nco_ctrl_pkg;

    localparam int DEF_PHI_W = 16;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// NCO control/sample path and FFT sink framing, grouped as one bundle.
interface nco_sweep_ctrl_if
    import nco_ctrl_pkg::*;
#(
    parameter int PHI_W = DEF_PHI_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic [PHI_W-1:0] phi_inc_o;
    logic             nco_clken_o;
    logic             nco_valid_i;
    logic [OUT_W-1:0] nco_sin_i;
    logic [OUT_W-1:0] nco_cos_i;
    logic             snk_ready_i;
    logic             snk_valid_o;
    logic             snk_sop_o;
    logic             snk_eop_o;
    logic [OUT_W-1:0] snk_sin_o;
    logic [OUT_W-1:0] snk_cos_o;

    modport master (
        output phi_inc_o, nco_clken_o, snk_valid_o, snk_sop_o, snk_eop_o, snk_sin_o, snk_cos_o,
        input  nco_valid_i, nco_sin_i, nco_cos_i, snk_ready_i
    );

    modport slave (
        input  phi_inc_o, nco_clken_o, snk_valid_o, snk_sop_o, snk_eop_o, snk_sin_o, snk_cos_o,
        output nco_valid_i, nco_sin_i, nco_cos_i, snk_ready_i
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Steps the NCO phase increment through a programmed sweep, drops a settle interval
// after each retune and forwards a framed, backpressure-safe burst per step.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int PHI_W = DEF_PHI_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [PHI_W-1:0] phi_start_i,
    input  logic [PHI_W-1:0] phi_step_i,
    input  logic [CNT_W-1:0] n_steps_i,
    input  logic [CNT_W-1:0] dwell_i,
    input  logic [CNT_W-1:0] settle_i,
    output logic [CNT_W-1:0] step_idx_o,
    output logic             busy_o,
    output logic             done_o,
    nco_sweep_ctrl_if.master bus
);

    state_t           state_r;
    logic [PHI_W-1:0] phi_inc_r;
    logic [PHI_W-1:0] phi_step_r;
    logic [CNT_W-1:0] n_steps_r;
    logic [CNT_W-1:0] dwell_r;
    logic [CNT_W-1:0] settle_r;
    logic [CNT_W-1:0] settle_cnt_r;
    logic [CNT_W-1:0] dwell_cnt_r;
    logic [CNT_W-1:0] step_idx_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             first_s;
    logic             last_s;
    logic             last_step_s;
    logic             clken_s;

    // Abort masks the accept so an aborted burst never shows an eop.
    assign accept_s    = (state_r == ST_DWELL) & bus.nco_valid_i & bus.snk_ready_i & ~abort_i;
    assign first_s     = (dwell_cnt_r == '0);
    assign last_s      = (dwell_cnt_r == (dwell_r - CNT_W'(1)));
    assign last_step_s = (step_idx_r == (n_steps_r - CNT_W'(1)));

    // NCO clock enable: free-running while settling, slaved to the sink while dwelling.
    always_comb begin
        clken_s = 1'b0;
        case (state_r)
            ST_SETTLE: clken_s = 1'b1;
            ST_DWELL:  clken_s = bus.snk_ready_i;
            default:   clken_s = 1'b0;
        endcase
    end

    assign bus.nco_clken_o = clken_s;
    assign bus.phi_inc_o   = phi_inc_r;
    assign bus.snk_valid_o = accept_s;
    assign bus.snk_sop_o   = accept_s & first_s;
    assign bus.snk_eop_o   = accept_s & last_s;
    assign bus.snk_sin_o   = bus.nco_sin_i;
    assign bus.snk_cos_o   = bus.nco_cos_i;
    assign step_idx_o      = step_idx_r;
    assign busy_o          = busy_r;
    assign done_o          = done_r;

    // Sweep sequencer: state, counters, latched config and registered status.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            phi_inc_r    <= '0;
            phi_step_r   <= '0;
            n_steps_r    <= '0;
            dwell_r      <= '0;
            settle_r     <= '0;
            settle_cnt_r <= '0;
            dwell_cnt_r  <= '0;
            step_idx_r   <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort_i) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_i && (n_steps_i != '0)) begin
                            phi_inc_r    <= phi_start_i;
                            phi_step_r   <= phi_step_i;
                            n_steps_r    <= n_steps_i;
                            dwell_r      <= (dwell_i == '0) ? CNT_W'(1) : dwell_i;
                            settle_r     <= settle_i;
                            settle_cnt_r <= '0;
                            dwell_cnt_r  <= '0;
                            step_idx_r   <= '0;
                            busy_r       <= 1'b1;
                            state_r      <= (settle_i == '0) ? ST_DWELL : ST_SETTLE;
                        end else if (start_i) begin
                            busy_r  <= 1'b1;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_r == (settle_r - CNT_W'(1))) begin
                            dwell_cnt_r <= '0;
                            state_r     <= ST_DWELL;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + CNT_W'(1);
                        end
                    end
                    ST_DWELL: begin
                        if (accept_s && last_s) begin
                            dwell_cnt_r <= '0;
                            if (last_step_s) begin
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end else begin
                                // Retune lands on the eop edge; phase wraps modulo 2^PHI_W.
                                phi_inc_r    <= phi_inc_r + phi_step_r;
                                step_idx_r   <= step_idx_r + CNT_W'(1);
                                settle_cnt_r <= '0;
                                state_r      <= (settle_r == '0) ? ST_DWELL : ST_SETTLE;
                            end
                        end else if (accept_s) begin
                            dwell_cnt_r <= dwell_cnt_r + CNT_W'(1);
                        end else begin
                            dwell_cnt_r <= dwell_cnt_r;
                        end
                    end
                    ST_DONE: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sequencer for the NCO in the fast-FFT datapath. On a start command it steps the NCO's phase increment through a programmed frequency sweep. After each retune it discards a settle interval, then forwards a fixed-length, framed burst of sin/cos samples to the FFT input. Downstream backpressure stalls the NCO through its clock enable, so no sample is lost or duplicated.

## Interface
- PHI_W, 16, phase-increment width; matches the NCO phi_inc_i.
- OUT_W, 16, NCO sin/cos sample width.
- CNT_W, 16, width of the step, dwell and settle counters.
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- start_i  in  1  one-cycle pulse; sampled only in IDLE.
- abort_i  in  1  level; forces IDLE from any state.
- phi_start_i  in  PHI_W  first phase increment; latched on accepted start.
- phi_step_i  in  PHI_W  increment added per step; latched.
- n_steps_i  in  CNT_W  number of frequency steps; latched.
- dwell_i  in  CNT_W  samples forwarded per step; latched; 0 is treated as 1.
- settle_i  in  CNT_W  clk cycles discarded after each retune; latched.
- nco_valid_i  in  1  NCO out_valid.
- nco_sin_i, nco_cos_i  in  OUT_W  NCO fsin_o/fcos_o.
- phi_inc_o  out  PHI_W  to NCO phi_inc_i; reset 0.
- nco_clken_o  out  1  to NCO clken; reset 0.
- snk_ready_i  in  1  FFT input ready.
- snk_valid_o, snk_sop_o, snk_eop_o  out  1  sample framing; reset 0.
- snk_sin_o, snk_cos_o  out  OUT_W  combinational passthrough of the NCO samples.
- step_idx_o  out  CNT_W  current step index; reset 0.
- busy_o  out  1  high when not in IDLE; reset 0.
- done_o  out  1  one-cycle pulse on sweep completion; reset 0.

## Operation
- States: IDLE, SETTLE, DWELL, DONE.
- IDLE: nco_clken_o=0.
  - On start_i with n_steps_i≠0: latch the config, set phi_inc_o<=phi_start_i and step_idx<=0. Go to SETTLE, or to DWELL if settle_i=0.
  - On start_i with n_steps_i=0: go to DONE; phi_inc_o is not updated.
- SETTLE: nco_clken_o=1 unconditionally; snk_valid_o=0; NCO output is dropped. Lasts exactly settle cycles, then goes to DWELL.
- DWELL:
  - nco_clken_o = snk_ready_i (combinational).
  - snk_valid_o = nco_valid_i & snk_ready_i.
  - accept = snk_valid_o; only accepted samples advance the dwell counter.
  - snk_sop_o is high on the first accept of a step; snk_eop_o is high on the dwell-th accept. For dwell=1, both are high on the same accept.
  - On the eop accept, if step_idx=n_steps-1, go to DONE.
  - Otherwise on the eop accept: phi_inc_o<=phi_inc_o+phi_step (modulo 2^PHI_W, wraps silently), step_idx++, and go to SETTLE (or DWELL if settle=0).
- DONE: done_o=1 for one cycle; nco_clken_o=0; next state IDLE.
- abort_i has priority over every transition. The next state is IDLE, with no done pulse and no eop. phi_inc_o and step_idx_o hold their values; busy_o drops on the next cycle.
- start_i outside IDLE is ignored. Config inputs are don't-care outside the start cycle.

## Timing
- Accepted start at edge T: busy_o=1 and the new phi_inc_o are visible after T.
- A retune takes effect on the same edge as the eop accept. The first cycle of SETTLE therefore already drives the new phi_inc_o.
- NCO stall rule: when snk_ready_i=0 in DWELL, clken is low and the NCO holds its output. The same sample is presented again once ready returns, and is consumed exactly once.
- Sweep length, with continuous ready and valid: 1 + n_steps·(settle+dwell) cycles from start to the done pulse.
- Reset (synchronous) returns to IDLE with all outputs at their reset values, including mid-sweep.

## Structure
- Shared package nco_ctrl_pkg: state enum, default PHI_W/OUT_W/CNT_W.
- Single module, no sub-modules. One next-state process plus registered counters (settle_cnt, dwell_cnt, step_idx).

## Test plan
- Basic sweep: phi_start=0x2AAB, step=0x1000, n_steps=3, dwell=4, settle=2, ready=1.
  - phi_inc_o sequence must be 0x2AAB, 0x3AAB, 0x4AAB.
  - 12 valid samples, with sop/eop at sample indices 0/3, 4/7, 8/11.
  - done_o pulses 19 cycles after start.
- Backpressure: toggle snk_ready_i pseudo-randomly during DWELL.
  - Exactly 4 accepts per step.
  - nco_clken_o tracks ready in DWELL.
  - No sample is repeated; compare against a bench phase accumulator.
- Edge configs:
  - n_steps=0: done one cycle after start, no valid samples.
  - dwell=0: one sample per step with sop=eop=1.
  - settle=0: DWELL entered directly, with no gap between steps.
- Wrap: phi_start=0xF000, step=0x2000, n_steps=2: second phi_inc_o=0x1000.
- Abort/reset: abort_i in the second step's DWELL gives IDLE next cycle, busy=0, no done pulse. A new start is accepted afterwards. reset_n low mid-SETTLE gives all outputs 0.
- Ignored start: start_i pulsed during DWELL does not change the latched config or the state.
